axi_lite_mem_slave: RTL

AXI4-Lite responder backed by a word-addressed register array; it is the far end of the bus block's master (m1) port. It accepts write address/data in either order, commits the write with byte strobes and returns a write response. It answers reads from the same array with one-cycle latency. Write and read paths run as independent state machines.

---
 rtl/axi_lite_mem_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder over a word-addressed array, independent write/read FSMs.
// Define AXI_MEM_SLVERR_EN to answer SLVERR for word indices >= DEPTH instead of wrapping modulo DEPTH.
module axi_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int SH = $clog2(BW);
  localparam int XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AXI_MEM_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  function automatic logic [31:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a >> SH);
  endfunction

  function automatic logic is_bad(input logic [31:0] w);
    return ERR_EN && (w >= 32'(DEPTH));
  endfunction

  // Out-of-range indices only reach the array when wrapping is enabled, so the modulo is always safe.
  function automatic logic [XW-1:0] slot_of(input logic [31:0] w);
    return XW'(w % 32'(DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wr_state_e             wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, c_addr;
  logic [DATA_WIDTH-1:0] wdata_q, c_data, merged;
  logic [BW-1:0]         wstrb_q, c_strb;
  logic                  aw_hs, w_hs, commit, w_bad;
  logic [XW-1:0]         w_slot;

  rd_state_e             rd_q, rd_d;
  logic                  ar_hs, r_bad;
  logic [XW-1:0]         r_slot;

  assign aw_hs  = s0_axi_awvalid && s0_axi_awready;
  assign w_hs   = s0_axi_wvalid && s0_axi_wready;
  assign ar_hs  = s0_axi_arvalid && s0_axi_arready;
  assign commit = (wr_q != WR_RESP) && (wr_d == WR_RESP);
  assign c_addr = (wr_q == WR_HAVE_ADDR) ? awaddr_q : s0_axi_awaddr;
  assign c_data = (wr_q == WR_HAVE_DATA) ? wdata_q : s0_axi_wdata;
  assign c_strb = (wr_q == WR_HAVE_DATA) ? wstrb_q : s0_axi_wstrb;
  assign w_bad  = is_bad(word_of(c_addr));
  assign w_slot = slot_of(word_of(c_addr));
  assign r_bad  = is_bad(word_of(s0_axi_araddr));
  assign r_slot = slot_of(word_of(s0_axi_araddr));

  always_comb begin
    wr_d = wr_q;
    case (wr_q)
      WR_IDLE:      wr_d = (aw_hs && w_hs) ? WR_RESP : aw_hs ? WR_HAVE_ADDR : w_hs ? WR_HAVE_DATA : WR_IDLE;
      WR_HAVE_ADDR: wr_d = w_hs ? WR_RESP : WR_HAVE_ADDR;
      WR_HAVE_DATA: wr_d = aw_hs ? WR_RESP : WR_HAVE_DATA;
      default:      wr_d = (s0_axi_bvalid && s0_axi_bready) ? WR_IDLE : WR_RESP;
    endcase
  end

  always_comb begin
    merged = mem[w_slot];
    for (int b = 0; b < BW; b++)
      merged[8*b +: 8] = c_strb[b] ? c_data[8*b +: 8] : merged[8*b +: 8];
  end

  // Readies are registered from the next state so they never depend combinationally on VALID.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wr_q           <= WR_IDLE;
      s0_axi_awready <= 1'b1;
      s0_axi_wready  <= 1'b1;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_bresp   <= 2'b00;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
    end else begin
      wr_q           <= wr_d;
      s0_axi_awready <= (wr_d == WR_IDLE) || (wr_d == WR_HAVE_DATA);
      s0_axi_wready  <= (wr_d == WR_IDLE) || (wr_d == WR_HAVE_ADDR);
      if (aw_hs) awaddr_q <= s0_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s0_axi_wdata;
        wstrb_q <= s0_axi_wstrb;
      end
      if (commit) begin
        s0_axi_bvalid <= 1'b1;
        s0_axi_bresp  <= w_bad ? 2'b10 : 2'b00;
      end else if (s0_axi_bvalid && s0_axi_bready) begin
        s0_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && !w_bad) begin
      mem[w_slot] <= merged;
    end
  end

  assign rd_d = (rd_q == RD_IDLE) ? (ar_hs ? RD_DATA : RD_IDLE)
                                  : ((s0_axi_rvalid && s0_axi_rready) ? RD_IDLE : RD_DATA);

  // The array read sees the pre-commit word when a write lands on the same edge.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rd_q           <= RD_IDLE;
      s0_axi_arready <= 1'b1;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rdata   <= '0;
      s0_axi_rresp   <= 2'b00;
    end else begin
      rd_q           <= rd_d;
      s0_axi_arready <= (rd_d == RD_IDLE);
      if (ar_hs) begin
        s0_axi_rvalid <= 1'b1;
        s0_axi_rdata  <= r_bad ? '0 : mem[r_slot];
        s0_axi_rresp  <= r_bad ? 2'b10 : 2'b00;
      end else if (s0_axi_rvalid && s0_axi_rready) begin
        s0_axi_rvalid <= 1'b0;
      end
    end
  end
endmodule
